// File: rtl/uart_tx_piso_cfg.sv
// UART transmit serialiser: start/data/parity/stop frame on the bit-rate clock, LSB first.
// Optional one-word holding register for back-to-back frames: define UART_TX_HOLD_EN.
module uart_tx_piso_cfg #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  input  logic [1:0]        parity_mode,
  output logic              ready,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_piso_cfg: DATA_W must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_piso_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              par_acc, par_acc_nxt;
  logic [1:0]        mode, mode_nxt;
  logic              tx_nxt, active_nxt, done_nxt;
  logic              accept, load_in, load_hold;
  logic [DATA_W-1:0] load_data;
  logic [1:0]        load_mode;

  function automatic logic has_parity(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // Parity bit from the running XOR of the data bits already sent.
  function automatic logic parity_bit(input logic acc, input logic [1:0] m);
    return acc ^ (m == 2'b10);
  endfunction

`ifdef UART_TX_HOLD_EN
  logic              hold_full, hold_full_nxt;
  logic [DATA_W-1:0] hold_data, hold_data_nxt;
  logic [1:0]        hold_mode, hold_mode_nxt;

  assign ready = !hold_full;
`else
  assign ready = !active_flag;
`endif

  assign accept = send && ready;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    par_acc_nxt = par_acc;
    mode_nxt    = mode;
    tx_nxt      = data_tx;
    active_nxt  = active_flag;
    done_nxt    = 1'b0;
    load_in     = 1'b0;
    load_hold   = 1'b0;
    load_data   = data_in;
    load_mode   = parity_mode;
`ifdef UART_TX_HOLD_EN
    hold_full_nxt = hold_full;
    hold_data_nxt = hold_data;
    hold_mode_nxt = hold_mode;
`endif

    case (state)
      IDLE: begin
        if (accept) load_in = 1'b1;
      end
      START: begin
        state_nxt   = DATA;
        cnt_nxt     = '0;
        tx_nxt      = shreg[0];
        par_acc_nxt = shreg[0];
        shreg_nxt   = shreg >> 1;
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          cnt_nxt = '0;
          if (has_parity(mode)) begin
            state_nxt = PARITY;
            tx_nxt    = parity_bit(par_acc, mode);
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
          tx_nxt      = shreg[0];
          par_acc_nxt = par_acc ^ shreg[0];
          shreg_nxt   = shreg >> 1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          tx_nxt     = 1'b1;
          active_nxt = 1'b0;
          done_nxt   = 1'b1;
`ifdef UART_TX_HOLD_EN
          // A queued word starts on the very edge the current frame ends.
          if (hold_full) begin
            load_hold     = 1'b1;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            load_in = 1'b1;
          end
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        tx_nxt     = 1'b1;
        active_nxt = 1'b0;
      end
    endcase

`ifdef UART_TX_HOLD_EN
    if (load_hold) begin
      load_data = hold_data;
      load_mode = hold_mode;
    end
    if (accept && !load_in) begin
      hold_full_nxt = 1'b1;
      hold_data_nxt = data_in;
      hold_mode_nxt = parity_mode;
    end
`endif

    if (load_in || load_hold) begin
      state_nxt   = START;
      shreg_nxt   = load_data;
      mode_nxt    = load_mode;
      cnt_nxt     = '0;
      par_acc_nxt = 1'b0;
      tx_nxt      = 1'b0;
      active_nxt  = 1'b1;
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      par_acc     <= 1'b0;
      mode        <= 2'b00;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      par_acc     <= par_acc_nxt;
      mode        <= mode_nxt;
      data_tx     <= tx_nxt;
      active_flag <= active_nxt;
      done_flag   <= done_nxt;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_mode <= 2'b00;
    end else begin
      hold_full <= hold_full_nxt;
      hold_data <= hold_data_nxt;
      hold_mode <= hold_mode_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_piso_cfg.sv
// Directed bench for uart_tx_piso_cfg: two instances (8-bit/1-stop and 5-bit/2-stop),
// expected line bits queued at send time and popped cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_piso_cfg;
`ifdef UART_TX_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_send = 1'b0;
  logic [1:0] a_mode = '0;
  logic       a_ready, a_tx, a_active, a_done;
  logic [4:0] b_data = '0;
  logic       b_send = 1'b0;
  logic [1:0] b_mode = '0;
  logic       b_ready, b_tx, b_active, b_done;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_piso_cfg #(.DATA_W(8), .STOP_BITS(1)) u_a (
    .baud_clk(clk), .reset(rst), .data_in(a_data), .send(a_send), .parity_mode(a_mode),
    .ready(a_ready), .data_tx(a_tx), .active_flag(a_active), .done_flag(a_done));

  uart_tx_piso_cfg #(.DATA_W(5), .STOP_BITS(2)) u_b (
    .baud_clk(clk), .reset(rst), .data_in(b_data), .send(b_send), .parity_mode(b_mode),
    .ready(b_ready), .data_tx(b_tx), .active_flag(b_active), .done_flag(b_done));

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [8:0] d, input int dw, input logic [1:0] m, input int sb);
    logic par;
    par = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
    end
    if (m == 2'b01) exp_q.push_back(par);
    else if (m == 2'b10) exp_q.push_back(!par);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic [1:0] m);
    int n;
    @(negedge clk);
    a_data = d; a_mode = m; a_send = 1'b1;
    push_frame({1'b0, d}, 8, m, 1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin a_send = 1'b0; a_data = ~d; a_mode = ~m; end
      chk("a_tx", a_tx, exp_q.pop_front());
      chk("a_active", a_active, 1'b1);
      chk("a_done", a_done, 1'b0);
      chk("a_ready", a_ready, HOLD);
    end
    @(negedge clk);
    chk("a_tx_end", a_tx, 1'b1);
    chk("a_active_end", a_active, 1'b0);
    chk("a_done_end", a_done, 1'b1);
    chk("a_ready_end", a_ready, 1'b1);
    @(negedge clk);
    chk("a_done_clr", a_done, 1'b0);
  endtask

  task automatic frame_b(input logic [4:0] d, input logic [1:0] m);
    int n;
    @(negedge clk);
    b_data = d; b_mode = m; b_send = 1'b1;
    push_frame({4'b0, d}, 5, m, 2);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin b_send = 1'b0; b_data = ~d; end
      if (!HOLD && i == 2) b_send = 1'b1;
      if (!HOLD && i == 3) b_send = 1'b0;
      chk("b_tx", b_tx, exp_q.pop_front());
      chk("b_active", b_active, 1'b1);
      chk("b_done", b_done, 1'b0);
      chk("b_ready", b_ready, HOLD);
    end
    @(negedge clk);
    chk("b_tx_end", b_tx, 1'b1);
    chk("b_active_end", b_active, 1'b0);
    chk("b_done_end", b_done, 1'b1);
    @(negedge clk);
    chk("b_done_clr", b_done, 1'b0);
    chk("b_active_idle", b_active, 1'b0);
  endtask

  initial begin
    // Reset and idle line
    #20 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_tx", a_tx, 1'b1);
      chk("rst_active", a_active, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_ready", a_ready, 1'b1);
      chk("rst_b_tx", b_tx, 1'b1);
    end

    // Parity modes on the 8-bit instance
    frame_a(8'b01001010, 2'b01);
    frame_a(8'b01001010, 2'b10);
    frame_a(8'b01001010, 2'b00);
    frame_a(8'hFF, 2'b11);
    frame_a(8'h01, 2'b10);

    // 5-bit, 2 stop bits; mid-frame send ignored in the default build
    frame_b(5'b10110, 2'b00);
    frame_b(5'b10110, 2'b01);

    // Reset during the 4th data bit
    @(negedge clk);
    a_data = 8'hF0; a_mode = 2'b01; a_send = 1'b1;
    @(negedge clk);
    a_send = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("abort_bit3", a_tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", a_tx, 1'b1);
    chk("abort_active", a_active, 1'b0);
    chk("abort_ready", a_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", a_done, 1'b0);
      chk("abort_idle", a_tx, 1'b1);
    end
    frame_a(8'h5A, 2'b01);

`ifdef UART_TX_HOLD_EN
    // Back-to-back through the hold register
    @(negedge clk);
    a_data = 8'hA5; a_mode = 2'b00; a_send = 1'b1;
    push_frame({1'b0, 8'hA5}, 8, 2'b00, 1);
    push_frame({1'b0, 8'h3C}, 8, 2'b00, 1);
    @(negedge clk);
    chk("hold_tx0", a_tx, exp_q.pop_front());
    chk("hold_ready0", a_ready, 1'b1);
    a_data = 8'h3C;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) a_send = 1'b0;
      chk("hold_tx", a_tx, exp_q.pop_front());
      chk("hold_active", a_active, 1'b1);
      chk("hold_done", a_done, i == 10);
      chk("hold_ready", a_ready, i >= 10);
    end
    @(negedge clk);
    chk("hold_end_tx", a_tx, 1'b1);
    chk("hold_end_active", a_active, 1'b0);
    chk("hold_end_done", a_done, 1'b1);
    @(negedge clk);
    chk("hold_done_clr", a_done, 1'b0);
`else
    // send held high: second frame waits one idle cycle
    @(negedge clk);
    a_data = 8'h3C; a_mode = 2'b11; a_send = 1'b1;
    push_frame({1'b0, 8'h3C}, 8, 2'b11, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_tx", a_tx, exp_q.pop_front());
      chk("held_ready", a_ready, 1'b0);
    end
    @(negedge clk);
    chk("held_gap_tx", a_tx, 1'b1);
    chk("held_gap_done", a_done, 1'b1);
    chk("held_gap_ready", a_ready, 1'b1);
    push_frame({1'b0, 8'h3C}, 8, 2'b11, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) a_send = 1'b0;
      chk("held2_tx", a_tx, exp_q.pop_front());
      chk("held2_active", a_active, 1'b1);
      chk("held2_done", a_done, 1'b0);
    end
    @(negedge clk);
    chk("held2_end_done", a_done, 1'b1);
    chk("held2_end_active", a_active, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
